sonar_uc: RTL

SONAR_UC -- requirements
Module: sonar_uc

---
 rtl/sonar_uc_pkg.sv | 20 ++
 rtl/sonar_uc_contador_m.sv | 29 ++
 rtl/sonar_uc.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sonar_uc_pkg.sv
// rtl/sonar_uc_pkg.sv - shared state encodings and defaults for the sonar sweep controller
package sonar_uc_pkg;

    localparam int NUM_CHARS_DEF      = 8;
    localparam int TIMEOUT_MEDIDA_DEF = 2_500_000;
    localparam int SEL_W              = 3;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        ESPERA_TX      = 4'd5,
        PROX_CHAR      = 4'd6,
        ATUALIZA       = 4'd7,
        ESPERA_TIMER   = 4'd8
    } estado_t;

endpackage

// File: rtl/sonar_uc_contador_m.sv
// rtl/sonar_uc_contador_m.sv - modulo-M counter flagging its terminal count
module contador_m #(
    parameter int M = 16,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [N-1:0] ULTIMO = N'(M - 1);

    logic [N-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + N'(1);
        end
    end

    assign fim = (q == ULTIMO);

endmodule

// File: rtl/sonar_uc.sv
// rtl/sonar_uc.sv - sonar sweep sequencer: measure, transmit characters, step position, wait timer
module sonar_uc
    import sonar_uc_pkg::*;
#(
    parameter int NUM_CHARS      = NUM_CHARS_DEF,
    parameter int TIMEOUT_MEDIDA = TIMEOUT_MEDIDA_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             pronto_medida,
    input  logic             pronto_serial,
    input  logic             fim_timer,
    output logic             reset_servo,
    output logic             zera_posicao,
    output logic             conta_posicao,
    output logic             zera_timer,
    output logic             conta_timer,
    output logic             medir,
    output logic             partida_serial,
    output logic [SEL_W-1:0] sel_letra,
    output logic             fim_ciclo,
    output logic             erro_medida,
    output logic [3:0]       db_estado
);

    localparam logic [SEL_W-1:0] ULTIMO_CHAR = SEL_W'(NUM_CHARS - 1);

    estado_t          estado, prox;
    logic [SEL_W-1:0] sel_prox;
    logic             retry, retry_prox;
    logic             erro_prox;
    logic             timeout;

    // Counter is cleared while requesting and counts only while waiting,
    // so the terminal count lands on the TIMEOUT_MEDIDA-th wait cycle.
    contador_m #(
        .M(TIMEOUT_MEDIDA)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado == MEDE),
        .conta (estado == AGUARDA_MEDIDA),
        .fim   (timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= INICIAL;
            sel_letra   <= '0;
            retry       <= 1'b0;
            erro_medida <= 1'b0;
        end else begin
            estado      <= prox;
            sel_letra   <= sel_prox;
            retry       <= retry_prox;
            erro_medida <= erro_prox;
        end
    end

    always_comb begin
        prox           = estado;
        sel_prox       = sel_letra;
        retry_prox     = retry;
        erro_prox      = erro_medida;
        reset_servo    = 1'b0;
        zera_posicao   = 1'b0;
        conta_posicao  = 1'b0;
        zera_timer     = 1'b0;
        conta_timer    = 1'b0;
        medir          = 1'b0;
        partida_serial = 1'b0;
        fim_ciclo      = 1'b0;
        case (estado)
            INICIAL: begin
                if (ligar) prox = PREPARA;
            end
            PREPARA: begin
                reset_servo  = 1'b1;
                zera_posicao = 1'b1;
                zera_timer   = 1'b1;
                retry_prox   = 1'b0;
                prox         = MEDE;
            end
            MEDE: begin
                medir = 1'b1;
                prox  = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: begin
                // A reply arriving on the timeout cycle still counts as valid.
                if (pronto_medida) begin
                    erro_prox = 1'b0;
                    prox      = TRANSMITE;
                end else if (timeout) begin
                    if (!retry) begin
                        retry_prox = 1'b1;
                        prox       = MEDE;
                    end else begin
                        erro_prox = 1'b1;
                        prox      = TRANSMITE;
                    end
                end
            end
            TRANSMITE: begin
                partida_serial = 1'b1;
                prox           = ESPERA_TX;
            end
            ESPERA_TX: begin
                if (pronto_serial) prox = PROX_CHAR;
            end
            PROX_CHAR: begin
                if (sel_letra == ULTIMO_CHAR) begin
                    sel_prox = '0;
                    prox     = ATUALIZA;
                end else begin
                    sel_prox = sel_letra + SEL_W'(1);
                    prox     = TRANSMITE;
                end
            end
            ATUALIZA: begin
                conta_posicao = 1'b1;
                zera_timer    = 1'b1;
                fim_ciclo     = 1'b1;
                retry_prox    = 1'b0;
                prox          = ESPERA_TIMER;
            end
            ESPERA_TIMER: begin
                conta_timer = 1'b1;
                if (fim_timer) prox = ligar ? MEDE : INICIAL;
            end
            default: begin
                prox = INICIAL;
            end
        endcase
    end

    assign db_estado = estado;

endmodule
